// File: rtl/cmd_proc_q.sv
// Line-follower command processor: queues packed step commands in a FIFO and
// sequences follow / veer / timed-reversal / bump-stop behaviour against line_present.
module cmd_proc_q #(
   parameter int          CMD_W      = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter int          ERR_W      = 16,
   parameter int unsigned VEER_ERR   = 'h0340,
   parameter int unsigned REV1_ERR   = 'h01E0,
   parameter int unsigned REV2_ERR   = 'h0380,
   parameter int          REV1_CYC   = 2883584,
   parameter int          REV2_CYC   = 65011712,
   parameter int          DBNC_CYC   = 4194304,
   parameter int          BUZZ_BIT   = 14
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CMD_W-1:0]              cmd,
   input  logic                          cmd_vld,
   output logic                          cmd_rdy,
   input  logic                          line_present,
   input  logic                          BMPL_n,
   input  logic                          BMPR_n,
   output logic                          go,
   output logic [ERR_W-1:0]              err_opn_lp,
   output logic                          buzz,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int CW      = PW + 1;
   localparam int MAX_A   = (REV1_CYC > REV2_CYC) ? REV1_CYC : REV2_CYC;
   localparam int MAX_CYC = (MAX_A > DBNC_CYC) ? MAX_A : DBNC_CYC;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0]    REV1_LAST = TW'(REV1_CYC - 1);
   localparam logic [TW-1:0]    REV2_LAST = TW'(REV2_CYC - 1);
   localparam logic [TW-1:0]    DBNC_LAST = TW'(DBNC_CYC - 1);
   localparam logic [ERR_W-1:0] VEER_MAG  = ERR_W'(VEER_ERR);
   localparam logic [ERR_W-1:0] REV1_MAG  = ERR_W'(REV1_ERR);
   localparam logic [ERR_W-1:0] REV2_MAG  = ERR_W'(REV2_ERR);

   typedef enum logic [2:0] {
      IDLE, FOLLOW, VEER, REV1, REV2, REV_WAIT, BUMP_DBNC, BUMP_HOLD
   } state_t;

   state_t state, state_nxt;

   logic [CMD_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push, pop, empty;

   logic [CMD_W-1:0] cur;
   logic             last_veer_right;
   logic [TW-1:0]    timer;
   logic [BUZZ_BIT:0] buzz_cnt;
   logic             bump, in_bump, nxt_in_bump;
   logic             load_cur, shift_cur, clr_cur, set_lvr, done_nxt;

   assign empty    = (count == '0);
   assign cmd_rdy  = (count != FULL_CNT);
   assign push     = cmd_vld & cmd_rdy;
   assign fifo_cnt = count;
   assign bump     = ~BMPL_n | ~BMPR_n;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_cur  = 1'b0;
      shift_cur = 1'b0;
      clr_cur   = 1'b0;
      set_lvr   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && line_present) begin
               pop       = 1'b1;
               load_cur  = 1'b1;
               state_nxt = FOLLOW;
            end
         end
         FOLLOW: begin
            if (bump) state_nxt = BUMP_DBNC;
            else if (!line_present) begin
               case (cur[1:0])
                  2'b00: begin
                     state_nxt = IDLE;
                     clr_cur   = 1'b1;
                     done_nxt  = 1'b1;
                  end
                  2'b11:   state_nxt = REV1;
                  default: state_nxt = VEER;
               endcase
            end else if (cur == '0 && !empty) begin
               pop      = 1'b1;
               load_cur = 1'b1;
            end
         end
         VEER: begin
            if (bump) state_nxt = BUMP_DBNC;
            else if (line_present) begin
               state_nxt = FOLLOW;
               set_lvr   = 1'b1;
               shift_cur = 1'b1;
            end
         end
         REV1: begin
            if (bump) state_nxt = BUMP_DBNC;
            else if (timer == REV1_LAST) state_nxt = REV2;
         end
         REV2: begin
            if (bump) state_nxt = BUMP_DBNC;
            else if (timer == REV2_LAST) state_nxt = REV_WAIT;
         end
         REV_WAIT: begin
            if (bump) state_nxt = BUMP_DBNC;
            else if (line_present) begin
               state_nxt = FOLLOW;
               shift_cur = 1'b1;
            end
         end
         BUMP_DBNC: begin
            if (timer == DBNC_LAST) state_nxt = bump ? BUMP_HOLD : FOLLOW;
         end
         BUMP_HOLD: begin
            if (!bump) state_nxt = FOLLOW;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_bump     = (state == BUMP_DBNC) || (state == BUMP_HOLD);
   assign nxt_in_bump = (state_nxt == BUMP_DBNC) || (state_nxt == BUMP_HOLD);

   // Any state change restarts the timer, so each timed state counts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cur             <= '0;
         last_veer_right <= 1'b0;
         timer           <= '0;
         buzz_cnt        <= '0;
         done            <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (load_cur)       cur <= mem[rd_ptr];
         else if (clr_cur)   cur <= '0;
         else if (shift_cur) cur <= cur >> 2;
         if (set_lvr) last_veer_right <= cur[0];
         if (state_nxt != state) timer <= '0;
         else if (state == REV1 || state == REV2 || state == BUMP_DBNC)
            timer <= timer + TW'(1);
         else timer <= '0;
         if (in_bump && nxt_in_bump) buzz_cnt <= buzz_cnt + (BUZZ_BIT+1)'(1);
         else buzz_cnt <= '0;
      end
   end

   always_comb begin
      go         = 1'b1;
      err_opn_lp = '0;
      case (state)
         IDLE, BUMP_DBNC, BUMP_HOLD: go = 1'b0;
         VEER: err_opn_lp = cur[0] ? VEER_MAG : -VEER_MAG;
         REV1: err_opn_lp = last_veer_right ? REV1_MAG : -REV1_MAG;
         REV2: err_opn_lp = last_veer_right ? -REV2_MAG : REV2_MAG;
         default: err_opn_lp = '0;
      endcase
   end

   assign buzz = buzz_cnt[BUZZ_BIT];
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmd_proc_q.sv
// Directed bench for cmd_proc_q with shortened timers and a fast buzz bit.
module tb_cmd_proc_q;

   logic        clk;
   logic        rst_n;
   logic [15:0] cmd;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        line_present;
   logic        BMPL_n;
   logic        BMPR_n;
   logic        go;
   logic [15:0] err_opn_lp;
   logic        buzz;
   logic        busy;
   logic        done;
   logic [2:0]  fifo_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   cmd_proc_q #(
      .REV1_CYC(20),
      .REV2_CYC(40),
      .DBNC_CYC(16),
      .BUZZ_BIT(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd(cmd),
      .cmd_vld(cmd_vld),
      .cmd_rdy(cmd_rdy),
      .line_present(line_present),
      .BMPL_n(BMPL_n),
      .BMPR_n(BMPR_n),
      .go(go),
      .err_opn_lp(err_opn_lp),
      .buzz(buzz),
      .busy(busy),
      .done(done),
      .fifo_cnt(fifo_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] c);
      cmd     = c;
      cmd_vld = 1'b1;
      waitCycles(1);
      cmd_vld = 1'b0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(1);
   endtask

   initial begin
      cmd = '0; cmd_vld = 0; line_present = 0; BMPL_n = 1; BMPR_n = 1; rst_n = 0;
      waitCycles(2);
      checkOutput("rst_go", go, 0);
      checkOutput("rst_err", err_opn_lp, 0);
      checkOutput("rst_buzz", buzz, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_rdy", cmd_rdy, 1);
      checkOutput("rst_cnt", fifo_cnt, 0);
      checkOutput("rst_busy", busy, 0);
      rst_n = 1;
      waitCycles(1);

      $display("[TB] single veer command");
      line_present = 1;
      applyStimulus(16'h0001);
      waitCycles(1);
      checkOutput("t1_follow_go", go, 1);
      checkOutput("t1_follow_cnt", fifo_cnt, 0);
      line_present = 0; waitCycles(1);
      checkOutput("t1_veer_err", err_opn_lp, 16'h0340);
      checkOutput("t1_veer_go", go, 1);
      line_present = 1; waitCycles(1);
      checkOutput("t1_back_err", err_opn_lp, 0);
      line_present = 0; waitCycles(1);
      checkOutput("t1_done", done, 1);
      checkOutput("t1_idle_go", go, 0);
      checkOutput("t1_idle_busy", busy, 0);
      waitCycles(1);
      checkOutput("t1_done_pulse", done, 0);

      $display("[TB] veer then reversal");
      line_present = 1;
      applyStimulus(16'h000D);
      waitCycles(1);
      line_present = 0; waitCycles(1);
      checkOutput("t2_veer_err", err_opn_lp, 16'h0340);
      line_present = 1; waitCycles(1);
      line_present = 0; waitCycles(1);
      checkOutput("t2_rev1_first", err_opn_lp, 16'h01E0);
      waitCycles(19);
      checkOutput("t2_rev1_last", err_opn_lp, 16'h01E0);
      waitCycles(1);
      checkOutput("t2_rev2_first", err_opn_lp, 16'hFC80);
      waitCycles(39);
      checkOutput("t2_rev2_last", err_opn_lp, 16'hFC80);
      waitCycles(1);
      checkOutput("t2_wait_err", err_opn_lp, 0);
      checkOutput("t2_wait_go", go, 1);
      waitCycles(5);
      checkOutput("t2_wait_hold", err_opn_lp, 0);
      line_present = 1; waitCycles(1);
      checkOutput("t2_follow_go", go, 1);
      line_present = 0; waitCycles(1);
      checkOutput("t2_done", done, 1);
      waitCycles(1);

      $display("[TB] two queued commands");
      applyStimulus(16'h0002);
      applyStimulus(16'h0001);
      checkOutput("t3_cnt2", fifo_cnt, 2);
      line_present = 1; waitCycles(1);
      checkOutput("t3_cnt1", fifo_cnt, 1);
      line_present = 0; waitCycles(1);
      checkOutput("t3_veer_left", err_opn_lp, 16'hFCC0);
      line_present = 1; waitCycles(2);
      checkOutput("t3_cnt0", fifo_cnt, 0);
      checkOutput("t3_no_done1", done, 0);
      line_present = 0; waitCycles(1);
      checkOutput("t3_veer_right", err_opn_lp, 16'h0340);
      line_present = 1; waitCycles(1);
      checkOutput("t3_no_done2", done, 0);
      line_present = 0; waitCycles(1);
      checkOutput("t3_done", done, 1);
      waitCycles(1);

      $display("[TB] fifo full");
      applyStimulus(16'h0001);
      applyStimulus(16'h0002);
      applyStimulus(16'h0001);
      applyStimulus(16'h0002);
      checkOutput("t4_full_rdy", cmd_rdy, 0);
      checkOutput("t4_full_cnt", fifo_cnt, 4);
      applyStimulus(16'h000D);
      checkOutput("t4_ignored_cnt", fifo_cnt, 4);
      line_present = 1; waitCycles(1);
      checkOutput("t4_pop_cnt", fifo_cnt, 3);
      checkOutput("t4_pop_rdy", cmd_rdy, 1);
      resetDut();

      $display("[TB] bump during veer");
      line_present = 1;
      applyStimulus(16'h0001);
      waitCycles(1);
      line_present = 0; waitCycles(1);
      checkOutput("t5_veer_err", err_opn_lp, 16'h0340);
      BMPL_n = 0; waitCycles(1);
      checkOutput("t5_dbnc_go", go, 0);
      checkOutput("t5_dbnc_err", err_opn_lp, 0);
      checkOutput("t5_buzz_lo", buzz, 0);
      waitCycles(4);
      checkOutput("t5_buzz_hi", buzz, 1);
      waitCycles(4);
      checkOutput("t5_buzz_lo2", buzz, 0);
      checkOutput("t5_busy", busy, 1);
      waitCycles(21);
      checkOutput("t5_hold_go", go, 0);
      BMPL_n = 1; waitCycles(1);
      checkOutput("t5_release_go", go, 1);
      checkOutput("t5_release_err", err_opn_lp, 0);
      checkOutput("t5_release_buzz", buzz, 0);
      waitCycles(1);
      checkOutput("t5_veer_retry", err_opn_lp, 16'h0340);
      resetDut();

      $display("[TB] reset during reversal");
      line_present = 1;
      applyStimulus(16'h000D);
      waitCycles(1);
      line_present = 0; waitCycles(1);
      line_present = 1; waitCycles(1);
      line_present = 0; waitCycles(1);
      waitCycles(20);
      checkOutput("t6_rev2_err", err_opn_lp, 16'hFC80);
      applyStimulus(16'h0001);
      checkOutput("t6_queued", fifo_cnt, 1);
      rst_n = 0;
      #2;
      checkOutput("t6_rst_go", go, 0);
      checkOutput("t6_rst_err", err_opn_lp, 0);
      checkOutput("t6_rst_cnt", fifo_cnt, 0);
      checkOutput("t6_rst_busy", busy, 0);
      waitCycles(1);
      rst_n = 1;
      line_present = 1;
      waitCycles(5);
      checkOutput("t6_idle_busy", busy, 0);
      checkOutput("t6_idle_go", go, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/cmd_proc_q.md
Name: cmd_proc_q

Overview:
Parametrised next-generation command processor for the line-follower. It accepts packed 2-bit step commands through a valid/ready interface and buffers them in an internal FIFO. It sequences them against line_present: follow, veer, or timed reversal, emitting go and a signed steering error err_opn_lp. Bumper hits stop the vehicle with a debounced buzzer hold. It sits between the UART command wrapper and the PID/motor path.

Parameters:
CMD_W, 16, command width; must be even; holds CMD_W/2 steps, LSB pair first
FIFO_DEPTH, 4, queued commands (power of 2, >=2)
ERR_W, 16, err_opn_lp width (signed two's complement)
VEER_ERR, 16'h0340, magnitude driven during a veer step
REV1_ERR, 16'h01E0, magnitude, reversal phase 1
REV2_ERR, 16'h0380, magnitude, reversal phase 2
REV1_CYC, 2883584, phase-1 duration in clk cycles
REV2_CYC, 65011712, phase-2 duration in clk cycles
DBNC_CYC, 4194304, bump debounce duration in clk cycles
BUZZ_BIT, 14, buzz = bit BUZZ_BIT of buzz counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cmd  in  CMD_W  packed step command
cmd_vld  in  1  cmd valid
cmd_rdy  out  1  FIFO not full; transfer when cmd_vld&cmd_rdy
line_present  in  1  line sensor detects line
BMPL_n  in  1  left bumper, active-low
BMPR_n  in  1  right bumper, active-low
go  out  1  motors enabled
err_opn_lp  out  ERR_W  open-loop steering error
buzz  out  1  piezo drive
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on command-list completion
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  queued command count

Behaviour:
- Reset: state IDLE, FIFO empty, cur=0, last_veer_right=0, timer=0, buzz counter=0; go=0, err_opn_lp=0, buzz=0, done=0, cmd_rdy=1, fifo_cnt=0.
- Step encoding (cur[1:0]): 00 end, 01 veer right (+VEER_ERR), 10 veer left (-VEER_ERR), 11 reversal.
- FIFO: push on cmd_vld&cmd_rdy. Simultaneous push+pop when full is illegal; cmd_rdy=0 when full. Simultaneous push+pop when not full keeps fifo_cnt. Pointers wrap at FIFO_DEPTH.
- Outputs are Moore, decoded from registered state; they change the cycle after a transition.
- States:
  - IDLE: go=0. If FIFO non-empty & line_present -> pop into cur, FOLLOW.
  - FOLLOW: go=1, err=0. If cur==0 & FIFO non-empty -> pop into cur (line still present). On !line_present: step 00 -> IDLE, cur<=0, done pulse next cycle; 01/10 -> VEER; 11 -> REV1, timer cleared.
  - VEER: go=1, err=+/-VEER_ERR. On line_present -> FOLLOW; last_veer_right<=cur[0]; cur<=cur>>2.
  - REV1: go=1, err=+REV1_ERR if last_veer_right else -REV1_ERR. After REV1_CYC cycles -> REV2, timer cleared.
  - REV2: sign opposite REV1, magnitude REV2_ERR. After REV2_CYC cycles -> REV_WAIT.
  - REV_WAIT: go=1, err=0. On line_present -> FOLLOW; cur<=cur>>2; last_veer_right unchanged.
- Bump: in FOLLOW/VEER/REV1/REV2/REV_WAIT, !BMPL_n|!BMPR_n has priority. Go to BUMP_DBNC, timer cleared, cur not shifted.
  - BUMP_DBNC: go=0, err=0, buzz counter runs. After DBNC_CYC -> BUMP_HOLD if any bumper still low, else FOLLOW.
  - BUMP_HOLD: same outputs as BUMP_DBNC. Both bumpers high -> FOLLOW.
  - Leaving bump states clears the buzz counter, so buzz=0.
- Interrupted step: an interrupted veer or reversal is re-evaluated from FOLLOW, so a reversal restarts from phase 1.
- Timers: duration compare is timer==CYC-1. Widths come from $clog2 of the largest CYC.
- Reset mid-operation: immediate return to reset values; the FIFO contents are lost.

Test Plan:
- Test parameters: REV1_CYC=20, REV2_CYC=40, DBNC_CYC=16.
- Push 16'h0001 with line_present=1. Drop the line -> go=1, err=16'h0340. Raise the line -> err=0. Drop again -> IDLE, done pulse, go=0.
- Push 16'h000D (01,11). First line loss: +0x0340. Second loss: +0x01E0 for 20 cycles, then 16'hFC80 (-0x0380) for 40 cycles, then 0 until the line returns.
- Push 16'h0002 then 16'h0001 before the first line loss. Steps run in order -> -0x0340 then +0x0340; done fires only after the second command; fifo_cnt goes 2->1->0.
- Push FIFO_DEPTH commands without a line -> cmd_rdy=0 and fifo_cnt=4. A fifth push is ignored. One pop -> cmd_rdy=1.
- In VEER, pull BMPL_n low for 30 cycles -> go=0, err=0, buzz toggles. Release -> FOLLOW; the same veer step re-executes on the next line loss.
- Assert rst_n=0 in REV2 -> go=0, err=0, fifo_cnt=0, and the block stays IDLE after release.
